// File: rtl/iter_div_unit_pkg.sv
// rtl/iter_div_unit_pkg.sv - shared state encodings and result width for the iterative divider
package iter_div_unit_pkg;

    // Divider controller states
    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

    // {remainder, quotient} width for the 32-bit datapath (HI:LO)
    localparam int DIV_RES_WD = 64;

endpackage

// File: rtl/iter_div_unit.sv
// rtl/iter_div_unit.sv - radix-2 restoring DIV/DIVU unit for one execute-stage issue slot
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 res_ack,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 complete,
    output logic [2*WIDTH-1:0]   div_res
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e        state;
    div_state_e        state_nxt;
    logic [CNT_W-1:0]  counter;

    // Partial remainder, quotient/dividend shift register, divisor magnitude
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  dsr_q;
    // Sign-correction flags captured at acceptance
    logic              neg_quo_q;
    logic              neg_rem_q;

    logic              accept;
    logic              last_step;
    logic [WIDTH:0]    r_sh;
    logic              borrow;
    logic [WIDTH-1:0]  diff_lo;
    logic              no_borrow;
    logic [WIDTH-1:0]  rem_step;
    logic [WIDTH-1:0]  quo_step;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // The most negative value maps onto itself, which is the correct unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    assign accept    = (state == DIV_ST_IDLE) && start && !cancel;
    assign last_step = (counter == CNT_W'(1));

    // One restoring step: shift {r, q} left, trial-subtract the divisor from the new r.
    // r_sh can need WIDTH+1 bits; when its top bit is set the subtraction cannot borrow,
    // and the low WIDTH bits of the difference are still exact.
    always_comb begin
        r_sh                = {rem_q, quo_q[WIDTH-1]};
        {borrow, diff_lo}   = {1'b0, r_sh[WIDTH-1:0]} - {1'b0, dsr_q};
        no_borrow           = r_sh[WIDTH] | ~borrow;
        rem_step            = no_borrow ? diff_lo : r_sh[WIDTH-1:0];
        quo_step            = {quo_q[WIDTH-2:0], no_borrow};
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIV_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a flush overrides everything else
    always_comb begin
        state_nxt = state;
        if (cancel) begin
            state_nxt = DIV_ST_IDLE;
        end else begin
            case (state)
                DIV_ST_IDLE: if (start)     state_nxt = DIV_ST_CALC;
                DIV_ST_CALC: if (last_step) state_nxt = DIV_ST_DONE;
                DIV_ST_DONE: if (res_ack)   state_nxt = DIV_ST_IDLE;
                default:                    state_nxt = DIV_ST_IDLE;
            endcase
        end
    end

    // Status outputs decode directly from the registered state
    always_comb begin
        busy     = (state != DIV_ST_IDLE);
        complete = (state == DIV_ST_DONE);
    end

    // Operand capture, iteration and result registration; a flush leaves div_res untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div_res   <= '0;
        end else if (cancel) begin
            counter   <= '0;
        end else if (accept) begin
            counter   <= CNT_W'(WIDTH);
            rem_q     <= '0;
            quo_q     <= magnitude(dividend, signed_op);
            dsr_q     <= magnitude(divisor, signed_op);
            // A zero divisor has a clear sign bit, so it naturally counts as positive
            neg_quo_q <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q <= signed_op & dividend[WIDTH-1];
        end else if (state == DIV_ST_CALC) begin
            counter   <= counter - CNT_W'(1);
            rem_q     <= rem_step;
            quo_q     <= quo_step;
            if (last_step) begin
                div_res <= {neg_rem_q ? negate(rem_step) : rem_step,
                            neg_quo_q ? negate(quo_step) : quo_step};
            end
        end
    end

endmodule
